// File: rtl/spi_cmd_master.sv
// spi_cmd_master: mode-0 SPI master issuing one instruction byte plus one data byte per command
module spi_cmd_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       sdo,
    input  logic       sdi
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [4:0]  bit_cnt;
    logic [14:0] tx_shift;
    logic [7:0]  rx_shift;
    logic [15:0] frame;
    logic        accept, tick;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign frame     = {cmd_write, 1'b0, cmd_addr, cmd_write ? cmd_wdata : 8'h00};
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    // next state and per-state terminal count of the shared counter
    always_comb begin
        state_next = state;
        tick       = 1'b0;
        case (state)
            IDLE: state_next = accept ? SETUP : IDLE;
            SETUP: begin
                tick       = cnt == 8'(CS_SETUP - 1);
                state_next = tick ? SHIFT : SETUP;
            end
            SHIFT: begin
                tick       = cnt == 8'(CLK_DIV - 1);
                state_next = (tick && sclk && bit_cnt == 5'd16) ? HOLD : SHIFT;
            end
            HOLD: begin
                tick       = cnt == 8'(CS_HOLD - 1);
                state_next = tick ? GAP : HOLD;
            end
            GAP: begin
                tick       = cnt == 8'(CS_IDLE - 1);
                state_next = tick ? IDLE : GAP;
            end
            default: state_next = IDLE;
        endcase
    end
    // datapath: counter, shift registers and SPI pins; the counter restarts on every terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            sdo       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            cnt       <= (state == IDLE || tick) ? 8'd0 : cnt + 8'd1;
            case (state)
                IDLE: if (accept) begin
                    tx_shift <= frame[14:0];
                    rx_shift <= '0;
                    bit_cnt  <= '0;
                    cs_n     <= 1'b0;
                    sdo      <= frame[15];
                end
                SHIFT: if (tick) begin
                    sclk <= ~sclk;
                    if (!sclk) begin
                        rx_shift <= {rx_shift[6:0], sdi};
                        bit_cnt  <= bit_cnt + 5'd1;
                    end else if (bit_cnt == 5'd16) begin
                        sdo <= 1'b0;
                    end else begin
                        sdo      <= tx_shift[14];
                        tx_shift <= {tx_shift[13:0], 1'b0};
                    end
                end
                HOLD: if (tick) begin
                    cs_n      <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rx_shift;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed checks of framing, timing, back-to-back, busy-ignore and mid-frame reset
module tb_spi_cmd_master;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, busy, sclk, cs_n, sdo, sdi;
    logic [7:0] rsp_rdata;
    logic [15:0] slave_resp = 16'h0000;
    logic [31:0] cap = '0;
    logic [7:0]  rdata_seen = '0;
    int n_checks = 0, n_pass = 0;
    int cyc = 0, rises = 0, falls = 0, fbit = 0;
    int low_cnt = 0, rsp_cnt = 0, rsp_cyc = 0, hs_cyc = 0;
    int n_frames = 0, hi_run = 0, last_gap = 0, ready_bad = 0;
    logic prev_cs = 1'b1;
    int r0, f0, l0, p0, n0;

    spi_cmd_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sclk(sclk), .cs_n(cs_n), .sdo(sdo), .sdi(sdi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // mode-0 slave: capture sdo on rising sclk, present the next response bit after each rise
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) fbit = 0;
        else begin
            cap = {cap[30:0], sdo};
            rises++;
            fbit++;
        end
    end
    always @(negedge sclk) falls++;
    assign sdi = (!cs_n && fbit < 16) ? slave_resp[4'(15 - fbit)] : 1'b0;

    // bus observer sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && !cs_n) low_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rdata_seen = rsp_rdata;
        end
        if (!cs_n && cmd_ready) ready_bad++;
        if (!cs_n && prev_cs) last_gap = hi_run;
        hi_run = cs_n ? hi_run + 1 : 0;
        if (cs_n && !prev_cs) n_frames++;
        prev_cs = cs_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic snap();
        r0 = rises; f0 = falls; l0 = low_cnt; p0 = rsp_cnt; n0 = n_frames;
    endtask

    // present a command at a falling edge and hold it until the accepting rising edge has passed
    task automatic issue(input logic w, input logic [5:0] a, input logic [7:0] d);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !cmd_ready; i++) @(negedge clk);
        hs_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 3000 && rsp_cnt < target; i++) @(negedge clk);
        check("rsp_arrive", rsp_cnt >= target, 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 3000 && rises < target; i++) @(negedge clk);
        check("rise_arrive", rises >= target, 1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {cs_n, sclk, sdo, rsp_valid, busy, cmd_ready, rsp_rdata},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        snap();
        issue(1'b1, 6'h03, 8'h5A);
        wait_rsp(p0 + 1);
        check("write_frame", cap[15:0], 16'h835A);
        check("write_rises", rises - r0, 16);
        check("write_falls", falls - f0, 16);
        check("write_cs_low", low_cnt - l0, 132);
        check("write_rsp_cnt", rsp_cnt - p0, 1);
        check("write_latency", rsp_cyc - hs_cyc, 133);

        snap();
        slave_resp = 16'h00C3;
        issue(1'b0, 6'h01, 8'hAB);
        wait_rsp(p0 + 1);
        check("read_frame", cap[15:0], 16'h0100);
        check("read_rdata_at_rsp", rdata_seen, 8'hC3);
        check("read_rsp_cnt", rsp_cnt - p0, 1);
        repeat (20) @(negedge clk);
        check("read_rdata_held", rsp_rdata, 8'hC3);

        snap();
        slave_resp = 16'h0000;
        cmd_write = 1'b1; cmd_addr = 6'h00; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_addr = 6'h3F; cmd_wdata = 8'hEE;
        for (int i = 0; i < 3000 && !cmd_ready; i++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(p0 + 2);
        check("b2b_frames", cap, 32'h8011_BFEE);
        check("b2b_frame_cnt", n_frames - n0, 2);
        check("b2b_rsp_cnt", rsp_cnt - p0, 2);
        check("b2b_cs_gap_ok", last_gap >= 2, 1);
        check("ready_during_cs", ready_bad, 0);

        snap();
        issue(1'b1, 6'h05, 8'h3C);
        cmd_wdata = 8'hFF;
        wait_rises(r0 + 5);
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 6'h2A; cmd_wdata = 8'h99; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(p0 + 1);
        repeat (40) @(negedge clk);
        check("busy_frame", cap[15:0], 16'h853C);
        check("busy_frame_cnt", n_frames - n0, 1);
        check("busy_rsp_cnt", rsp_cnt - p0, 1);
        check("busy_rises", rises - r0, 16);

        snap();
        issue(1'b1, 6'h07, 8'hA5);
        wait_rises(r0 + 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {cs_n, sclk, sdo, busy, rsp_valid}, 5'b10000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - p0, 0);

        snap();
        slave_resp = 16'h005C;
        issue(1'b0, 6'h02, 8'h00);
        wait_rsp(p0 + 1);
        check("post_abort_frame", cap[15:0], 16'h0200);
        check("post_abort_rdata", rdata_seen, 8'h5C);
        check("post_abort_cs_low", low_cnt - l0, 132);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
